mini_core_egress_buf: RTL
=========================

# mini_core_egress_buf

Egress buffer and port selector between `mini_core_top`'s outbound fabric interface (`OutFabricQ505H` / `OutFabricValidQ505H`) and the 5-port tile fabric. It absorbs core-originated packets in a small FIFO, computes the XY-routed output port for the head packet from its destination tile id, and forwards it when that port's `fab_ready` bit is high. It decouples the core pipeline from fabric stalls and raises a sticky flag on any lost packet.

## Interface
- `PKT_W`, 64: packet width in bits.
- `DEST_MSB`, 63: MSB of the 8-bit destination tile id field, `pkt[DEST_MSB:DEST_MSB-7]`.
- `DEPTH`, 4: FIFO entries, power of 2, ≥2.

- `Clock`  in  1  single clock; all state updates on rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `local_tile_id`  in  8  this tile: `[7:4]`=X, `[3:0]`=Y. Static after reset.
- `InValidQ505H`  in  1  core offers packet.
- `InPktQ505H`  in  PKT_W  core packet.
- `InReadyQ505H`  out  1  buffer can accept; high iff `Count != DEPTH`.
- `fab_ready`  in  5  per-port ready: [0]=N, [1]=E, [2]=S, [3]=W, [4]=Local.
- `OutPktQ506H`  out  PKT_W  head packet; driven from FIFO storage.
- `OutValidQ506H`  out  5  one-hot valid on selected port; all zero when empty.
- `Overflow`  out  1  sticky: a packet was offered while full.
- `Count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH×PKT_W array, write pointer, read pointer, occupancy counter (pointers wrap modulo DEPTH).
- Push: `InValidQ505H && InReadyQ505H` writes `InPktQ505H` at write pointer, increments write pointer.
- Drop: `InValidQ505H && !InReadyQ505H` discards the packet and sets `Overflow`; cleared only by `Rst`.
- Port selection on head dest id D (dx=D[7:4], dy=D[3:0]; lx, ly from `local_tile_id`), X first:
  - dx > lx → E; dx < lx → W;
  - else dy > ly → S; dy < ly → N;
  - else Local.
- `OutValidQ506H` = one-hot of selected port when `Count != 0`, else 5'b0.
- Pop: `|(OutValidQ506H & fab_ready)` advances read pointer. Ready on non-selected ports is ignored.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- No bypass: a packet pushed into an empty buffer is not visible in the same cycle.
- Head packet and port stay stable while valid and not popped (no reordering, no port switching).

## Timing
- Reset (`Rst` high at edge): pointers=0, `Count`=0, `Overflow`=0. Hence `OutValidQ506H`=0 and `InReadyQ505H`=1 from the first cycle after reset. `OutPktQ506H` is don't-care while invalid.
- Reset mid-operation discards all buffered packets. No output valid in the cycle following reset.
- Latency: a packet pushed at edge N is presented with valid from cycle N+1 (Q506H). If its port is ready, it pops at edge N+1.
- Throughput: 1 packet/cycle sustained when the selected port is continuously ready.
- `InReadyQ505H` derives from registered `Count` only. When full, a same-cycle pop does not enable a push: `InReadyQ505H`=0 and an offered packet is dropped with `Overflow` set.
- Push and pop in the same cycle at 0<Count<DEPTH: `Count` is unchanged and both pointers advance.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0. Ordering is preserved across wrap.

## Test plan
- Reset/idle: `Rst` 2 cycles → `Count`=0, `OutValidQ506H`=5'b0, `InReadyQ505H`=1, `Overflow`=0.
- Routing with `local_tile_id`=8'h22: dest 8'h32→E (5'b00010), 8'h12→W (5'b01000), 8'h23→S (5'b00100), 8'h21→N (5'b00001), 8'h22→Local (5'b10000), 8'h31→E (X first). Each appears the cycle after push with `fab_ready`=5'h1F and pops the next edge.
- Backpressure/fill: `fab_ready`=0, push 5 packets (A..E) → A..D accepted, `Count`=4, `InReadyQ505H`=0, E dropped, `Overflow`=1. Then `fab_ready`=5'h1F → A,B,C,D emerge in order on consecutive cycles, `Count`→0, `Overflow` stays 1.
- Wrong-port ready: head routed E, `fab_ready`=5'b11101 for 3 cycles → no pop, head and `OutValidQ506H` stable. Set bit1 → pop the next edge.
- Streaming/wrap: 20 back-to-back pushes with all ready → each packet out exactly 1 cycle after push, `Count` stays ≤1, no drops, order preserved through 5 pointer wraps.
- Reset mid-operation: `Count`=3, assert `Rst` 1 cycle → next cycle `Count`=0, `OutValidQ506H`=0, `Overflow`=0. A new push emerges correctly 1 cycle later.

Source files
------------

// File: rtl/mini_core_egress_buf_if.sv
// Handshake bundle between the core's outbound port, the egress buffer and
// the 5-port tile fabric.
interface mini_core_egress_buf_if #(
  parameter int PKT_W = 64
);
  logic             InValidQ505H;
  logic [PKT_W-1:0] InPktQ505H;
  logic             InReadyQ505H;
  logic [4:0]       fab_ready;
  logic [PKT_W-1:0] OutPktQ506H;
  logic [4:0]       OutValidQ506H;

  modport master (
    output InValidQ505H, InPktQ505H, fab_ready,
    input  InReadyQ505H, OutPktQ506H, OutValidQ506H
  );

  modport slave (
    input  InValidQ505H, InPktQ505H, fab_ready,
    output InReadyQ505H, OutPktQ506H, OutValidQ506H
  );
endinterface

// File: rtl/mini_core_egress_buf.sv
// Egress FIFO between the core and the tile fabric: XY-routes the head packet
// and pops it when the selected port is ready; sticky flag on dropped packets.
module mini_core_egress_buf #(
  parameter int PKT_W    = 64,
  parameter int DEST_MSB = 63,
  parameter int DEPTH    = 4
) (
  input  logic                         Clock,
  input  logic                         Rst,
  input  logic [7:0]                   local_tile_id,
  mini_core_egress_buf_if.slave        bus,
  output logic                         Overflow,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic       ready;
  logic       push;
  logic       drop;
  logic       pop;
  logic [7:0] dest;
  logic [4:0] port_sel;
  logic [4:0] out_valid;

  // Ready comes from registered occupancy only, so a pop never frees a slot
  // for a push in the same cycle.
  assign ready = (count_q != FULL);
  assign push  = bus.InValidQ505H && ready;
  assign drop  = bus.InValidQ505H && !ready;

  assign dest = mem[rd_ptr][DEST_MSB -: 8];

  always_comb begin
    port_sel = 5'b10000;
    if (dest[7:4] > local_tile_id[7:4])      port_sel = 5'b00010;
    else if (dest[7:4] < local_tile_id[7:4]) port_sel = 5'b01000;
    else if (dest[3:0] > local_tile_id[3:0]) port_sel = 5'b00100;
    else if (dest[3:0] < local_tile_id[3:0]) port_sel = 5'b00001;
  end

  assign out_valid = (count_q != '0) ? port_sel : 5'b00000;
  assign pop       = |(out_valid & bus.fab_ready);

  always_ff @(posedge Clock) begin
    if (Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= bus.InPktQ505H;
  end

  assign bus.InReadyQ505H  = ready;
  assign bus.OutValidQ506H = out_valid;
  assign bus.OutPktQ506H   = mem[rd_ptr];
  assign Overflow          = overflow_q;
  assign Count             = count_q;
endmodule
